// File: rtl/mesi_pkg.sv
// Shared MESI definitions: line-state codes, bus FSM states and request types.
package mesi_pkg;

  localparam logic [1:0] MESI_M = 2'b00;
  localparam logic [1:0] MESI_E = 2'b01;
  localparam logic [1:0] MESI_S = 2'b11;
  localparam logic [1:0] MESI_I = 2'b10;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_SNOOP = 2'd1,
    BUS_WAIT  = 2'd2,
    BUS_RESP  = 2'd3
  } bus_state_e;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  // A line holds data unless it is Invalid.
  function automatic logic line_valid(input logic [1:0] st);
    return st != MESI_I;
  endfunction

endpackage

// File: rtl/mesi_snoop_bus_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  always_comb begin
    int cand;
    cand  = 0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = IDXW'(cand);
      end
    end
    gnt = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/mesi_snoop_bus.sv
// Snooping-bus controller for N MESI caches: arbitrate, broadcast BR/BW, return Shared.
// Optional MESI_BUS_STATS_EN adds saturating read/write transaction counters.
module mesi_snoop_bus
  import mesi_pkg::*;
#(
  parameter int N_CACHES = 4,
  parameter int MEM_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CACHES-1:0]   req_valid,
  input  logic [N_CACHES-1:0]   req_wr,
  input  logic [2*N_CACHES-1:0] line_state,
  output logic [N_CACHES-1:0]   grant,
  output logic [N_CACHES-1:0]   bus_br,
  output logic [N_CACHES-1:0]   bus_bw,
  output logic [N_CACHES-1:0]   bus_s,
  output logic [N_CACHES-1:0]   done,
  output logic                  busy
`ifdef MESI_BUS_STATS_EN
  ,
  output logic [15:0]           rd_cnt,
  output logic [15:0]           wr_cnt
`endif
);

  localparam int         IDXW     = $clog2(N_CACHES);
  localparam logic [3:0] CNT_LOAD = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

  bus_state_e          state_reg, state_next;
  logic [IDXW-1:0]     ptr_reg, owner_reg, arb_idx;
  logic [N_CACHES-1:0] grant_reg, arb_gnt, line_live;
  logic                wr_reg, shared_reg, arb_found;
  logic [3:0]          cnt_reg;

  rr_arbiter #(.N(N_CACHES), .IDXW(IDXW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .found (arb_found)
  );

  for (genvar gi = 0; gi < N_CACHES; gi++) begin : g_live
    assign line_live[gi] = line_valid(line_state[2*gi +: 2]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= BUS_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BUS_IDLE:  if (arb_found) state_next = BUS_SNOOP;
      BUS_SNOOP: state_next = (MEM_LAT > 0) ? BUS_WAIT : BUS_RESP;
      BUS_WAIT:  if (cnt_reg == 4'd0) state_next = BUS_RESP;
      BUS_RESP:  state_next = BUS_IDLE;
      default:   state_next = BUS_IDLE;
    endcase
  end

  // Owner, type, counter and Shared capture; Shared is sampled before snoopers react.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg    <= '0;
      owner_reg  <= '0;
      grant_reg  <= '0;
      wr_reg     <= READ;
      cnt_reg    <= 4'd0;
      shared_reg <= 1'b0;
    end else begin
      case (state_reg)
        BUS_IDLE: if (arb_found) begin
          owner_reg <= arb_idx;
          grant_reg <= arb_gnt;
          wr_reg    <= req_wr[arb_idx];
        end
        BUS_SNOOP: begin
          shared_reg <= |(line_live & ~grant_reg);
          cnt_reg    <= CNT_LOAD;
        end
        BUS_WAIT: if (cnt_reg != 4'd0) cnt_reg <= cnt_reg - 4'd1;
        BUS_RESP: ptr_reg <= (int'(owner_reg) == N_CACHES - 1) ? '0 : owner_reg + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    grant  = '0;
    bus_br = '0;
    bus_bw = '0;
    bus_s  = '0;
    done   = '0;
    busy   = (state_reg != BUS_IDLE);
    case (state_reg)
      BUS_SNOOP: begin
        grant = grant_reg;
        if (wr_reg == READ) bus_br = ~grant_reg;
        else                bus_bw = ~grant_reg;
      end
      BUS_WAIT: grant = grant_reg;
      BUS_RESP: begin
        grant = grant_reg;
        done  = grant_reg;
        if (wr_reg == READ && shared_reg) bus_s = grant_reg;
      end
      default: ;
    endcase
  end

`ifdef MESI_BUS_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt <= 16'd0;
      wr_cnt <= 16'd0;
    end else if (state_reg == BUS_SNOOP) begin
      if (wr_reg == READ && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      if (wr_reg == WRITE && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mesi_snoop_bus.sv
// Randomized scoreboard bench for mesi_snoop_bus (N_CACHES=4, MEM_LAT=2).
module tb_mesi_snoop_bus;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_wr = '0;
  logic [2*N-1:0] line_state = '0;
  logic [N-1:0]   grant, bus_br, bus_bw, bus_s, done;
  logic           busy;
`ifdef MESI_BUS_STATS_EN
  logic [15:0]    rd_cnt, wr_cnt;
`endif

  mesi_snoop_bus #(.N_CACHES(N), .MEM_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_wr     (req_wr),
    .line_state (line_state),
    .grant      (grant),
    .bus_br     (bus_br),
    .bus_bw     (bus_bw),
    .bus_s      (bus_s),
    .done       (done),
    .busy       (busy)
`ifdef MESI_BUS_STATS_EN
    ,
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int owner;
    bit wr;
    bit s_exp;
  } exp_t;
  exp_t sb_q[$];

  int ptr_m = 0;
  int rd_m = 0;
  int wr_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Shared = some other cache holds the line in a non-Invalid state.
  function automatic bit model_shared(input int owner, input logic [7:0] ls);
    logic [1:0] st;
    for (int i = 0; i < N; i++) begin
      st = ls[2*i +: 2];
      if (i != owner && st != 2'b10) return 1'b1;
    end
    return 1'b0;
  endfunction

  // A held request set is served in round-robin order starting at the model pointer.
  task automatic push_batch(input logic [3:0] r, input logic [3:0] w, input logic [7:0] ls);
    int   last;
    int   c;
    exp_t e;
    last = -1;
    for (int k = 0; k < N; k++) begin
      c = (ptr_m + k) % N;
      if (r[c]) begin
        e.owner = c;
        e.wr    = w[c];
        e.s_exp = !w[c] && model_shared(c, ls);
        sb_q.push_back(e);
        if (w[c]) wr_m++;
        else      rd_m++;
        last = c;
      end
    end
    if (last >= 0) ptr_m = (last + 1) % N;
  endtask

  task automatic drain();
    for (int t = 0; t < 80 && req_valid != '0; t++) begin
      @(negedge clk);
      req_valid = req_valid & ~done;
    end
    check("batch_drain", 32'(req_valid), 32'h0);
  endtask

  task automatic run_batch(input logic [3:0] r, input logic [3:0] w, input logic [7:0] ls);
    @(negedge clk);
    line_state = ls;
    req_wr     = w;
    req_valid  = r;
    push_batch(r, w, ls);
    drain();
  endtask

  initial begin : monitor
    int         snoop_cyc;
    exp_t       e;
    logic [3:0] oh;
    logic [3:0] nb;
    snoop_cyc = -1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        snoop_cyc = -1;
      end else begin
        if ((bus_br | bus_bw) != '0) begin
          if (sb_q.size() == 0) begin
            check("unexpected_snoop", 32'(bus_br | bus_bw), 32'h0);
          end else begin
            e  = sb_q[0];
            oh = 4'b0001 << e.owner;
            nb = ~oh;
            check("snoop_grant", 32'(grant), 32'(oh));
            check("snoop_br", 32'(bus_br), e.wr ? 32'h0 : 32'(nb));
            check("snoop_bw", 32'(bus_bw), e.wr ? 32'(nb) : 32'h0);
          end
          snoop_cyc = cyc;
        end
        if (done != '0) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'h0);
          end else begin
            e  = sb_q.pop_front();
            oh = 4'b0001 << e.owner;
            check("done_owner", 32'(done), 32'(oh));
            check("resp_grant", 32'(grant), 32'(oh));
            check("bus_s", 32'(bus_s), e.s_exp ? 32'(oh) : 32'h0);
            check("resp_latency", 32'(cyc - snoop_cyc), 32'(LAT + 1));
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] ls;
    repeat (3) @(negedge clk);
    check("in_reset_quiet", 32'({grant, bus_br, bus_bw, bus_s, done, busy}), 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_quiet", 32'({grant, bus_br, bus_bw, bus_s, done, busy}), 32'h0);
    end

    run_batch(4'b1111, 4'b0000, 8'($urandom));
    run_batch(4'b0001, 4'b0000, 8'($urandom));
    run_batch(4'b0010, 4'b0000, 8'hAB);
    run_batch(4'b0100, 4'b0100, 8'h68);

    for (int b = 0; b < 40; b++)
      run_batch(4'($urandom_range(1, 15)), 4'($urandom), 8'($urandom));

    // Abort during WAIT; the held request must be re-served from a cleared pointer.
    ls = 8'($urandom);
    @(negedge clk);
    line_state = ls;
    req_wr     = 4'b0000;
    req_valid  = 4'b1000;
    push_batch(4'b1000, 4'b0000, ls);
    repeat (2) @(posedge clk);
    #1;
    check("busy_in_wait", 32'(busy), 32'h1);
    check("grant_in_wait", 32'(grant), 32'h8);
    rst = 1'b0;
    #1;
    check("abort_outputs", 32'({grant, bus_br, bus_bw, bus_s, done, busy}), 32'h0);
    sb_q.delete();
    ptr_m = 0;
    rd_m  = 0;
    wr_m  = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push_batch(4'b1000, 4'b0000, ls);
    drain();

    for (int b = 0; b < 6; b++)
      run_batch(4'($urandom_range(1, 15)), 4'($urandom), 8'($urandom));

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
`ifdef MESI_BUS_STATS_EN
    check("rd_cnt", 32'(rd_cnt), 32'(rd_m));
    check("wr_cnt", 32'(wr_cnt), 32'(wr_m));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mesi_snoop_bus.md
Name: mesi_snoop_bus

Overview:
Shared snooping-bus controller that sits between N per-line MESI cache FSMs. It is the bus side of the MESI protocol.
- Arbitrates processor-miss requests from the caches.
- Broadcasts the bus-read/bus-write strobes (the br/bw snoop inputs) to every non-requesting cache.
- Computes the Shared line from the other caches' states and returns it, with a completion pulse, to the requester.

Parameters:
N_CACHES, 4, number of attached caches (2..16)
MEM_LAT, 2, memory-fill wait cycles between snoop and response (0..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  N_CACHES  per-cache bus request; held high until matching done pulse
req_wr  input  N_CACHES  per-cache request type: 0 = bus read (BR), 1 = bus write (BW)
line_state  input  2*N_CACHES  current MESI state of each cache, cache i at bits [2i+1:2i]
grant  output  N_CACHES  one-hot owner of current transaction, held for the whole transaction
bus_br  output  N_CACHES  one-cycle BR snoop strobe to every cache except the owner
bus_bw  output  N_CACHES  one-cycle BW snoop strobe to every cache except the owner
bus_s  output  N_CACHES  Shared result, valid only in owner bit during its done pulse
done  output  N_CACHES  one-cycle completion pulse to owner
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (rst low, async): FSM = IDLE, round-robin pointer = 0, latency counter = 0, owner/type regs = 0. All outputs = 0.
- State encoding (shared package): M=2'b00, E=2'b01, S=2'b11, I=2'b10. Any other code on line_state is treated as I.
- FSM states: IDLE, SNOOP, WAIT, RESP (registered, 2-bit).
- IDLE:
  - If any req_valid bit is set, select the first set bit at or after the pointer, wrapping from N_CACHES-1 to 0.
  - Latch the owner index and req_wr[owner]; go to SNOOP.
  - If no request, stay in IDLE.
- grant asserts one-hot from the first SNOOP cycle through the RESP cycle inclusive.
- SNOOP (exactly 1 cycle):
  - If the latched type is read, bus_br = ~grant; otherwise bus_bw = ~grant. The other strobe vector is 0.
  - shared_q <= OR over i != owner of (line_state[i] != I). Sampled in this same cycle, i.e. before the snooped FSMs update.
  - Next state: WAIT if MEM_LAT > 0 (counter loaded with MEM_LAT-1), else RESP.
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 0. Occupies exactly MEM_LAT cycles.
- RESP (1 cycle):
  - done[owner] = 1; bus_s[owner] = shared_q for a read, 0 for a write.
  - Pointer <= owner+1 mod N_CACHES.
  - Next state is IDLE.
- Latency from a request sampled in IDLE to done: MEM_LAT+2 cycles. Next grant no earlier than the cycle after RESP.
- Outputs are registered-state decoded. bus_br/bus_bw/done/bus_s are 0 in every state other than the one named above.
- Owner drops req_valid mid-transaction: the transaction still completes normally; the drop is not checked.
- Non-owner req_valid changes during a transaction: ignored until IDLE.
- Simultaneous requests: round-robin only. A requester waits at most N_CACHES-1 transactions.
- Reset mid-transaction: immediate abort to the reset values. No done pulse is issued.
- N_CACHES=2: a snoop strobe goes to exactly the one other cache.

Optional Feature:
Macro MESI_BUS_STATS_EN.
- Defined: adds outputs rd_cnt[15:0] and wr_cnt[15:0].
  - Each increments in the SNOOP cycle of a read or write transaction respectively.
  - Each saturates at 16'hFFFF and resets to 0.
- Not defined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package mesi_pkg: MESI state localparams (M/E/S/I), bus FSM state codes, request-type constants READ=0 and WRITE=1.
- One sub-module rr_arbiter (N_CACHES request vector plus pointer in, one-hot grant plus index out, purely combinational), instantiated once.
- FSM, counter and shared logic stay in mesi_snoop_bus.

Test Plan (N_CACHES=4, MEM_LAT=2):
- Reset release, no requests -> all outputs 0, busy 0 indefinitely.
- Cache 1 read; line_state: cache0 = S, others I -> bus_br = 4'b1101 for one cycle, then 2 WAIT cycles, then done = 4'b0010 with bus_s[1] = 1, four cycles after the request is sampled.
- Cache 2 write; caches 0,1,3 = M,I,E -> bus_bw = 4'b1011 pulse, bus_br = 0, done = 4'b0100, bus_s = 0.
- req_valid = 4'b1111 held, pointer at 0 -> grants in the order 0,1,2,3,0; each done precedes the next grant.
- Cache 3 read, rst pulsed low during WAIT -> outputs 0 immediately, no done pulse; after release the still-held request is re-granted to cache 3 with pointer restarted at 0.
- MEM_LAT=0 build, cache 0 read, all others I -> done[0] one cycle after SNOOP with bus_s[0] = 0.
- With MESI_BUS_STATS_EN: 3 reads and 2 writes -> rd_cnt = 3, wr_cnt = 2.
